// File: rtl/bus_arbiter_n.sv
// Shared memory-bus arbiter: grant/own/release FSM with an acknowledge timeout and an encoded owner ID.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin winner selection; the default build is fixed priority (lowest index).
module bus_arbiter_n #(
  parameter int NUM_REQ     = 5,
  parameter int ID_WIDTH    = $clog2(NUM_REQ),
  parameter int ACK_TIMEOUT = 8,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REQ-1:0]  bus_req,
  input  logic                bus_busy,
  output logic [NUM_REQ-1:0]  bus_grant,
  output logic                grant_valid,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                timeout_pulse
);

  typedef enum logic [1:0] {IDLE, GRANT, OWNED, RELEASE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 win_found;
  logic [ID_WIDTH-1:0]  win_idx;
  logic                 owner_req;

  // The grant register is one-hot, so masking the requests with it yields the owner's own request.
  assign owner_req = |(bus_req & bus_grant);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [ID_WIDTH-1:0] ptr;
  int                  dist;
  int                  best_dist;

  // Winner is the requester closest above the pointer, wrapping round.
  always_comb begin
    win_found = |bus_req;
    win_idx   = '0;
    dist      = 0;
    best_dist = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist = (i - int'(ptr) - 1 + 2 * NUM_REQ) % NUM_REQ;
      if (bus_req[i] && (dist < best_dist)) begin
        best_dist = dist;
        win_idx   = ID_WIDTH'(i);
      end
    end
  end
`else
  always_comb begin
    win_found = |bus_req;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus_req[i]) win_idx = ID_WIDTH'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bus_grant     <= '0;
      grant_valid   <= 1'b0;
      grant_id      <= '0;
      timeout_pulse <= 1'b0;
      cnt           <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr           <= ID_WIDTH'(NUM_REQ - 1);
`endif
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus_busy && win_found) begin
            bus_grant   <= NUM_REQ'(1) << win_idx;
            grant_valid <= 1'b1;
            grant_id    <= win_idx;
            cnt         <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          // Busy beats withdrawal, which beats timeout; a withdrawal never raises the timeout pulse.
          if (bus_busy) begin
            state <= OWNED;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            ptr   <= grant_id;
`endif
          end else if (!owner_req || (cnt == CNT_WIDTH'(ACK_TIMEOUT - 1))) begin
            state         <= IDLE;
            bus_grant     <= '0;
            grant_valid   <= 1'b0;
            grant_id      <= '0;
            timeout_pulse <= owner_req;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        OWNED: begin
          if (!bus_busy) begin
            state       <= RELEASE;
            bus_grant   <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
